zap_mem_model: RTL and testbench

Parametrised, cycle-accurate memory model for ZAP core benches. It serves either the instruction or the data port and generalises the fixed single-mode cache model. It adds:
- a direct-mapped tag array with configurable miss latency
- byte and halfword access with sign/zero extension
- a programmable abort window
- a misalignment abort
- an explicit abort/recover handshake

---
 rtl/zap_mem_model.sv | 186 ++++++++++++++++++
 tb/tb_zap_mem_model.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/zap_mem_model.sv
// zap_mem_model: cycle-accurate instruction/data memory model for ZAP benches.
// Direct-mapped tag array with miss stalls, sub-word access and abort handling.
module zap_mem_model #(
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          NUM_LINES    = 16,
    parameter int          LINE_WORDS   = 4,
    parameter int          MISS_LATENCY = 3,
    parameter logic [31:0] ABORT_BASE   = 32'hFFFF_0000,
    parameter logic [31:0] ABORT_LIMIT  = 32'hFFFF_FFFF,
    parameter string       INIT_FILE    = ""
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic        i_unsigned_byte_en,
    input  logic        i_signed_byte_en,
    input  logic        i_unsigned_halfword_en,
    input  logic        i_signed_halfword_en,
    output logic        o_hit,
    output logic        o_miss,
    output logic        o_abort,
    input  logic        i_recover
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LW = $clog2(NUM_LINES);
    localparam int TL = 2 + OW + LW;
    localparam int TW = 32 - TL;
    localparam int CW = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    logic [31:0]    r_mem [DEPTH_WORDS];
    logic [TW-1:0]  r_tag [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [LW-1:0]  r_fill_line;
    logic [TW-1:0]  r_fill_tag;

    logic [IW-1:0]  w_idx;
    logic [LW-1:0]  w_line;
    logic [TW-1:0]  w_tag;
    logic           w_byte;
    logic           w_half;
    logic           w_sext;
    logic           w_req;
    logic           w_err;
    logic           w_lookup;
    logic           w_we;
    logic [31:0]    w_word;
    logic [7:0]     w_b8;
    logic [15:0]    w_h16;
    logic [31:0]    w_rdata;
    logic [31:0]    w_wdata;
    logic [3:0]     w_be;

    assign w_idx  = i_address[IW+1:2];
    assign w_line = i_address[TL-1:2+OW];
    assign w_tag  = i_address[31:TL];

    assign w_byte = i_unsigned_byte_en | i_signed_byte_en;
    assign w_half = i_unsigned_halfword_en | i_signed_halfword_en;
    assign w_sext = i_signed_byte_en | i_signed_halfword_en;
    assign w_req  = i_rd_en | i_wr_en;

    // 33-bit compares keep the window test meaningful at the address-space ends
    assign w_err = (({1'b0, i_address} >= {1'b0, ABORT_BASE}) &&
                    ({1'b0, i_address} <= {1'b0, ABORT_LIMIT})) ||
                   (w_half && i_address[0]);

    assign w_lookup = (MISS_LATENCY == 0) ? 1'b1 :
                      (r_valid[w_line] && (r_tag[w_line] == w_tag));

    assign w_word = r_mem[w_idx];
    assign w_b8   = w_word[{i_address[1:0], 3'b000} +: 8];
    assign w_h16  = i_address[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rdata = w_word;
        if (w_byte) begin
            w_rdata = {{24{w_sext & w_b8[7]}}, w_b8};
        end else if (w_half) begin
            w_rdata = {{16{w_sext & w_h16[15]}}, w_h16};
        end
    end

    always_comb begin
        w_wdata = i_data;
        w_be    = 4'b1111;
        if (w_byte) begin
            w_wdata = {4{i_data[7:0]}};
            w_be    = 4'b0001 << i_address[1:0];
        end else if (w_half) begin
            w_wdata = {2{i_data[15:0]}};
            w_be    = i_address[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        o_hit   = 1'b0;
        o_miss  = 1'b0;
        o_abort = 1'b0;
        o_data  = '0;
        w_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_err) begin
                        o_abort = 1'b1;
                    end else if (w_lookup) begin
                        o_hit  = 1'b1;
                        o_data = i_rd_en ? w_rdata : '0;
                        w_we   = i_wr_en & ~i_reset;
                    end else begin
                        o_miss = 1'b1;
                    end
                end
            end
            S_FILL:  o_miss  = 1'b1;
            S_ABORT: o_abort = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            if (w_be[0]) r_mem[w_idx][7:0]   <= w_wdata[7:0];
            if (w_be[1]) r_mem[w_idx][15:8]  <= w_wdata[15:8];
            if (w_be[2]) r_mem[w_idx][23:16] <= w_wdata[23:16];
            if (w_be[3]) r_mem[w_idx][31:24] <= w_wdata[31:24];
        end
    end

    // Tags are only meaningful behind a valid bit, so only valids reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_err) begin
                        r_state <= S_ABORT;
                    end else if (o_miss) begin
                        if (MISS_LATENCY == 1) begin
                            r_valid[w_line] <= 1'b1;
                            r_tag[w_line]   <= w_tag;
                        end else begin
                            r_state     <= S_FILL;
                            r_cnt       <= CW'(MISS_LATENCY - 1);
                            r_fill_line <= w_line;
                            r_fill_tag  <= w_tag;
                        end
                    end
                end
                S_FILL: begin
                    if (i_recover) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_valid[r_fill_line] <= 1'b1;
                        r_tag[r_fill_line]   <= r_fill_tag;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ABORT: begin
                    if (i_recover) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zap_mem_model.sv
// tb_zap_mem_model: directed scoreboard bench for zap_mem_model.
// Expected read data is queued at issue and checked when o_hit arrives.
module tb_zap_mem_model;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        i_rd_en;
    logic        i_wr_en;
    logic        i_ub;
    logic        i_sb;
    logic        i_uh;
    logic        i_sh;
    logic        o_hit;
    logic        o_miss;
    logic        o_abort;
    logic        i_recover;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q [$];

    zap_mem_model dut (
        .i_clk                  (clk),
        .i_reset                (i_reset),
        .i_address              (i_address),
        .i_data                 (i_data),
        .o_data                 (o_data),
        .i_rd_en                (i_rd_en),
        .i_wr_en                (i_wr_en),
        .i_unsigned_byte_en     (i_ub),
        .i_signed_byte_en       (i_sb),
        .i_unsigned_halfword_en (i_uh),
        .i_signed_halfword_en   (i_sh),
        .o_hit                  (o_hit),
        .o_miss                 (o_miss),
        .o_abort                (o_abort),
        .i_recover              (i_recover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sz: 0 word, 1 unsigned byte, 2 signed byte, 3 unsigned half, 4 signed half
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int sz);
        i_rd_en   = rd;
        i_wr_en   = wr;
        i_address = a;
        i_data    = d;
        i_ub      = (sz == 1);
        i_sb      = (sz == 2);
        i_uh      = (sz == 3);
        i_sh      = (sz == 4);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int sz, input logic [31:0] exp,
                          input int exp_stall);
        int          stall;
        logic        hit;
        logic        done;
        logic [31:0] got;
        logic [31:0] e;
        if (rd) sb_q.push_back(exp);
        drive(rd, wr, a, d, sz);
        stall = 0;
        hit   = 1'b0;
        done  = 1'b0;
        got   = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (o_hit) begin
                hit  = 1'b1;
                got  = o_data;
                done = 1'b1;
            end else if (o_miss) begin
                stall++;
            end else begin
                done = 1'b1;
            end
            step();
        end
        idle();
        chk({tag, "_hit"}, {31'b0, hit}, 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        if (rd && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, got, e);
        end
    endtask

    initial begin
        int n_ab;
        int n_hit;
        i_reset   = 1'b1;
        i_recover = 1'b0;
        idle();
        step();
        step();
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_hit", {31'b0, o_hit}, 32'd0);
        chk("rst_miss", {31'b0, o_miss}, 32'd0);
        chk("rst_abort", {31'b0, o_abort}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        step();

        // Miss latency, hit after fill, eviction and same-line re-read
        access("t1_wr100", 0, 1, 32'h100, 32'hCAFE_0100, 0, 32'h0, 3);
        access("t1_wr104", 0, 1, 32'h104, 32'hDEAD_BEEF, 0, 32'h0, 0);
        access("t1_wr200", 0, 1, 32'h200, 32'h1234_80F0, 0, 32'h0, 3);
        access("t1_rd100", 1, 0, 32'h100, 32'h0, 0, 32'hCAFE_0100, 3);
        access("t1_rd104", 1, 0, 32'h104, 32'h0, 0, 32'hDEAD_BEEF, 0);

        // Sub-word extension
        access("t2_sb200", 1, 0, 32'h200, 32'h0, 2, 32'hFFFF_FFF0, 3);
        access("t2_ub201", 1, 0, 32'h201, 32'h0, 1, 32'h0000_0080, 0);
        access("t2_sh202", 1, 0, 32'h202, 32'h0, 4, 32'h0000_1234, 0);
        access("t2_sh200", 1, 0, 32'h200, 32'h0, 4, 32'hFFFF_80F0, 0);
        access("t2_ub203", 1, 0, 32'h203, 32'h0, 1, 32'h0000_0012, 0);

        // Lane writes and read-during-write
        access("t3_wr210", 0, 1, 32'h210, 32'h1111_1111, 0, 32'h0, 3);
        access("t3_wb213", 0, 1, 32'h213, 32'h0000_00AB, 1, 32'h0, 0);
        access("t3_rd210", 1, 0, 32'h210, 32'h0, 0, 32'hAB11_1111, 0);
        access("t3_wr214", 0, 1, 32'h214, 32'h1111_1111, 0, 32'h0, 0);
        access("t3_rw214", 1, 1, 32'h214, 32'hAB11_1111, 0, 32'h1111_1111, 0);
        access("t3_rd214", 1, 0, 32'h214, 32'h0, 0, 32'hAB11_1111, 0);

        // Abort window held for five cycles without recover
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 0);
        n_ab  = 0;
        n_hit = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_ab  += int'(o_abort);
            n_hit += int'(o_hit);
            step();
            if (c == 4) begin
                i_recover = 1'b1;
                i_rd_en   = 1'b0;
            end
            if (c == 5) i_recover = 1'b0;
        end
        idle();
        chk("t4_abort_cycles", 32'(n_ab), 32'd6);
        chk("t4_no_hit", 32'(n_hit), 32'd0);

        // Misaligned halfword read and write both abort
        drive(1'b1, 1'b0, 32'h301, 32'h0, 4);
        @(negedge clk);
        chk("t4_mis_rd", {31'b0, o_abort}, 32'd1);
        step();
        idle();
        i_recover = 1'b1;
        step();
        i_recover = 1'b0;
        drive(1'b0, 1'b1, 32'h201, 32'h0000_5555, 3);
        @(negedge clk);
        chk("t4_mis_wr", {31'b0, o_abort}, 32'd1);
        step();
        idle();
        i_recover = 1'b1;
        @(negedge clk);
        chk("t4_abort_state", {31'b0, o_abort}, 32'd1);
        step();
        i_recover = 1'b0;
        access("t4_nowrite", 1, 0, 32'h200, 32'h0, 0, 32'h1234_80F0, 0);

        // Aliasing lines evict each other
        access("t5_wr000", 0, 1, 32'h000, 32'h0A0A_0A0A, 0, 32'h0, 3);
        access("t5_rd100", 1, 0, 32'h100, 32'h0, 0, 32'hCAFE_0100, 3);
        access("t5_rd000", 1, 0, 32'h000, 32'h0, 0, 32'h0A0A_0A0A, 3);

        // Recover during the second fill cycle cancels the install
        drive(1'b0, 1'b1, 32'h020, 32'h7777_7777, 0);
        @(negedge clk);
        chk("t6_miss_c0", {31'b0, o_miss}, 32'd1);
        step();
        step();
        i_recover = 1'b1;
        @(negedge clk);
        chk("t6_miss_c2", {31'b0, o_miss}, 32'd1);
        step();
        i_recover = 1'b0;
        idle();
        @(negedge clk);
        chk("t6_miss_drop", {31'b0, o_miss}, 32'd0);
        step();
        access("t6_wr020", 0, 1, 32'h020, 32'h7777_7777, 0, 32'h0, 3);
        access("t6_rd020", 1, 0, 32'h020, 32'h0, 0, 32'h7777_7777, 0);

        // Reset mid-fill clears state and every valid bit
        drive(1'b1, 1'b0, 32'h100, 32'h0, 0);
        step();
        i_reset = 1'b1;
        idle();
        step();
        i_reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_miss", {31'b0, o_miss}, 32'd0);
        chk("t6_rst_hit", {31'b0, o_hit}, 32'd0);
        chk("t6_rst_abort", {31'b0, o_abort}, 32'd0);
        step();
        access("t6_rd020r", 1, 0, 32'h020, 32'h0, 0, 32'h7777_7777, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
